// File: rtl/shares_unmask_stage.sv
// Unmasking stage: normalises a d-share masked word to share-major layout,
// XOR-recombines the shares and optionally word-reverses the result.
module shares_unmask_stage #(
    parameter int d     = 2,
    parameter int COUNT = 128,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COUNT*d-1:0]   in_data,
    input  logic                 in_fmt_shbus,
    input  logic                 in_swap,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COUNT*d-1:0]   out_shares,
    output logic [COUNT-1:0]     out_data
);

    localparam int NW = COUNT / WIDTH;

    logic [COUNT*d-1:0] shares_d;
    logic [COUNT-1:0]   value;
    logic [COUNT-1:0]   data_d;
    logic               take;

    logic               out_valid_q;
    logic [COUNT*d-1:0] out_shares_q;
    logic [COUNT-1:0]   out_data_q;

    always_comb begin
        shares_d = in_data;
        if (in_fmt_shbus) begin
            for (int i = 0; i < COUNT; i++) begin
                for (int s = 0; s < d; s++) begin
                    shares_d[s*COUNT+i] = in_data[i*d+s];
                end
            end
        end
        value = '0;
        for (int s = 0; s < d; s++) begin
            value = value ^ shares_d[s*COUNT +: COUNT];
        end
        data_d = value;
        if (in_swap) begin
            for (int w = 0; w < NW; w++) begin
                data_d[w*WIDTH +: WIDTH] = value[(NW-1-w)*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !out_valid_q | out_ready;
    assign take     = in_valid & in_ready;

    // Data registers only move on a transfer so a drained result stays observable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_shares_q <= '0;
            out_data_q   <= '0;
        end else begin
            if (take) begin
                out_valid_q  <= 1'b1;
                out_shares_q <= shares_d;
                out_data_q   <= data_d;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_shares = out_shares_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_shares_unmask_stage.sv
// Self-checking bench for shares_unmask_stage (d=2, COUNT=128, WIDTH=8).
module tb_shares_unmask_stage;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         in_fmt_shbus;
    logic         in_swap;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_shares;
    logic [127:0] out_data;

    typedef struct packed {
        logic [255:0] sh;
        logic [127:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks;
    int failures;

    shares_unmask_stage #(.d(2), .COUNT(128), .WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_fmt_shbus(in_fmt_shbus),
        .in_swap(in_swap),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_shares(out_shares),
        .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input logic [255:0] din,
                                   input logic fmt, input logic swp);
        exp_t r;
        logic [127:0] s0, s1, v;
        if (fmt) begin
            for (int i = 0; i < 128; i++) begin
                s0[i] = din[2*i];
                s1[i] = din[2*i+1];
            end
        end else begin
            s0 = din[127:0];
            s1 = din[255:128];
        end
        v = s0 ^ s1;
        r.sh = {s1, s0};
        r.dat = v;
        if (swp)
            for (int b = 0; b < 16; b++)
                r.dat[8*b +: 8] = v[8*(15-b) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Drive one word; the caller decides when it is accepted.
    task automatic drive(input logic [255:0] din, input logic fmt,
                         input logic swp);
        in_valid     = 1'b1;
        in_data      = din;
        in_fmt_shbus = fmt;
        in_swap      = swp;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_fmt_shbus = 1'b0;
        in_swap = 1'b0;
        out_ready = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_shares !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h", out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_plain(input logic swp, input logic [127:0] want);
        logic [255:0] din;
        din = {128'h0, 128'h00112233445566778899aabbccddeeff};
        @(negedge clk);
        out_ready = 1'b1;
        drive(din, 1'b0, swp);
        exp_q.push_back('{sh: din, dat: want});
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL plain_valid: got %b want 1", out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e.dat) begin
            failures++;
            $display("FAIL plain_data: got %h want %h", out_data, e.dat);
        end
        checks++;
        if (out_shares !== e.sh) begin
            failures++;
            $display("FAIL plain_shares: got %h want %h", out_shares, e.sh);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== e.dat) begin
            failures++;
            $display("FAIL drain_hold: valid=%b data=%h want 0/%h",
                     out_valid, out_data, e.dat);
        end
    endtask

    task automatic test_masked();
        logic [127:0] m, k;
        m = 128'h0123456789abcdef0123456789abcdef;
        k = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        @(negedge clk);
        drive({m ^ k, m}, 1'b0, 1'b0);
        exp_q.push_back('{sh: {m ^ k, m}, dat: k});
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e.dat) begin
            failures++;
            $display("FAIL masked_data: valid=%b got %h want %h",
                     out_valid, out_data, e.dat);
        end
    endtask

    task automatic test_shbus();
        logic [127:0] x;
        logic [255:0] din;
        x = 128'h3243f6a8885a308d313198a2e0370734;
        for (int i = 0; i < 128; i++) begin
            din[2*i]   = ~x[i];
            din[2*i+1] = 1'b1;
        end
        @(negedge clk);
        drive(din, 1'b1, 1'b0);
        exp_q.push_back('{sh: {{128{1'b1}}, ~x}, dat: x});
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e.dat) begin
            failures++;
            $display("FAIL shbus_data: valid=%b got %h want %h",
                     out_valid, out_data, e.dat);
        end
        checks++;
        if (out_shares !== e.sh) begin
            failures++;
            $display("FAIL shbus_shares: got %h want %h", out_shares, e.sh);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] a, b;
        logic fa, sa, fb, sb;
        a = rnd256(); fa = 1'b1; sa = 1'b0;
        b = rnd256(); fb = 1'b0; sb = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(a, fa, sa);
        exp_q.push_back(model(a, fa, sa));
        @(negedge clk);
        drive(b, fb, sb);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_data !== exp_q[0].dat || out_shares !== exp_q[0].sh) begin
                failures++;
                $display("FAIL stall_hold: cyc=%0d valid=%b in_ready=%b data=%h want %h",
                         c, out_valid, in_ready, out_data, exp_q[0].dat);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(model(b, fb, sb));
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e.dat || out_shares !== e.sh) begin
            failures++;
            $display("FAIL no_gap_load: valid=%b got %h want %h",
                     out_valid, out_data, e.dat);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] w;
        logic f, s;
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_valid: word=%0d valid=%b", k - 1, out_valid);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e.dat || out_shares !== e.sh) begin
                        failures++;
                        $display("FAIL stream_data: word=%0d got %h want %h",
                                 k - 1, out_data, e.dat);
                    end
                end
            end
            if (k < 3) begin
                w = rnd256(); f = k[0]; s = k[1] | k[0];
                drive(w, f, s);
                exp_q.push_back(model(w, f, s));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [255:0] w;
        w = rnd256();
        @(negedge clk);
        out_ready = 1'b0;
        drive(w, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_shares !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%h shares=%h",
                     out_valid, out_data, out_shares);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: in_ready=%b valid=%b", in_ready, out_valid);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_plain(1'b0, 128'h00112233445566778899aabbccddeeff);
        test_plain(1'b1, 128'hffeeddccbbaa99887766554433221100);
        test_masked();
        test_shbus();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
